lpf_channel_scheduler: RTL and testbench
========================================

Name: lpf_channel_scheduler

Overview:
- Time-multiplexes one shared first-order IIR low-pass update, y += (x − y) >>> k, across NCH signed 20-bit channels.
- Generates the sample-rate strobe internally from qzt_clk and snapshots all channel inputs on that strobe.
- Sequences the channels one at a time through the update and holds per-channel filter state and per-channel k.
- Sits between the ADC/sample capture logic and downstream display/relay-control logic.

Parameters:
- DIV, 50000, qzt_clk cycles per sample period (legal range: ≥ 2).
- NCH, 4, number of channels (legal range: 1..8).
- W, 20, sample width in bits (signed).

Ports:
- qzt_clk  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  1 = divider runs and ticks are generated; 0 = divider held at 0.
- cfg_we  input  1  one-cycle write strobe for a channel's k.
- cfg_ch  input  3  channel index for cfg_we; values ≥ NCH are ignored.
- cfg_k  input  4  new k for cfg_ch.
- clear_state  input  1  pulse: zero all filter state.
- vin  input  NCH*W  packed inputs; channel c occupies [c*W +: W].
- vout  output  NCH*W  packed filter outputs (registered state y).
- vout_valid  output  1  one-cycle pulse when a full frame update has completed.
- sample_tick  output  1  one-cycle pulse at each sample strobe.
- busy  output  1  high while a frame is being processed.
- overrun  output  1  sticky; set when a tick arrives while busy.

Behaviour:
- Reset (async, reset_n = 0): vout = 0, all k registers = 0, shadow k = 0, divider = 0, FSM = IDLE, and busy, vout_valid, sample_tick, overrun all 0.
- Divider:
  - While enable = 1, it counts 0..DIV−1.
  - sample_tick = 1 for the single cycle in which the count wraps from DIV−1 to 0.
  - enable = 0 resets the count to 0 synchronously; no ticks are generated and filter state is retained.
- Configuration:
  - cfg_we writes cfg_k into k[cfg_ch] in the same cycle.
  - On each accepted tick, all k values are copied to shadow registers. The frame uses only the shadow values, so a write during busy takes effect at the next frame.
- FSM states: IDLE, LOAD, UPDATE, DONE.
  - IDLE, tick present: latch all vin into the snapshot, latch shadow k, set ch = 0, go to LOAD, busy = 1.
  - LOAD: read x = snap[ch], y = vout[ch], kk = shadow_k[ch] into pipeline registers; go to UPDATE.
  - UPDATE:
    - Compute the W+1-bit signed d = x − y, then a = d >>> kk (arithmetic shift, floors toward −inf).
    - Write vout[ch] = y + a, truncated to W bits. The result always lies between y and x, so no overflow can occur and no saturation logic is required.
    - If ch = NCH−1, go to DONE; otherwise ch++ and go to LOAD.
  - DONE: vout_valid = 1 for one cycle, busy = 0, go to IDLE.
  - Latency: vout_valid asserts 2*NCH + 1 cycles after the sample_tick cycle (9 cycles for NCH = 4).
- k = 0 gives y = x, i.e. pass-through.
- k = 15 applied to |d| < 2^15 gives a = 0 for positive d and a = −1 for negative d (floor).
- Overrun: a tick while busy ≠ 0 is dropped (no re-trigger, snapshot unchanged) and sets overrun = 1. overrun clears only on reset.
- clear_state:
  - In IDLE with no tick in the same cycle: all vout are zeroed next cycle.
  - Otherwise the request is stored as pending and applied in the cycle after DONE, before any new frame.
  - A tick arriving in the same cycle as the pending clear is applied: the clear wins, and the tick is accepted one cycle later (at most one-cycle delay; not counted as overrun).
- cfg_we and a tick in the same cycle: the new k is captured into the shadow, i.e. the write wins.
- vout changes only in UPDATE and on clear. Between vout_valid pulses it holds, and it is partially updated while busy = 1.
- Asynchronous reset mid-frame aborts the frame immediately: all state returns to the reset values and no vout_valid is produced.

Test Plan:
1. DIV = 10, NCH = 4, all k = 0, enable = 1, vin = {100, −200, 524287, −524288} → sample_tick every 10 cycles; vout_valid 9 cycles after each tick; vout equals vin exactly.
2. k[0] = 2, vin0 held at 1000 from y = 0 → successive frames give y0 = 250, 437, 577, 682, …; the sequence is monotone and never exceeds 1000.
3. k[1] = 15, y1 = 0, vin1 = −1 → y1 = −1 after one frame (floor); vin1 = +1 with y1 = 0 → y1 stays 0.
4. DIV = 5, NCH = 4 → overrun = 1 after the first re-tick during busy; frames still complete; overrun remains set across later frames.
5. cfg_we for ch 2 with k = 3 asserted mid-frame → that frame uses the old k, the next frame uses k = 3; cfg_ch = 6 → no k register changes.
6. clear_state during busy, then reset_n pulsed mid-frame → clear is applied the cycle after DONE (all vout = 0); the reset mid-frame gives vout = 0, busy = 0, no vout_valid pulse.

Source files
------------

// File: rtl/lpf_channel_scheduler.sv
// Shared first-order IIR low-pass (y += (x - y) >>> k) time-multiplexed over NCH channels.
// Latency: vout_valid 2*NCH+1 cycles after the accepted sample tick.
// Backpressure: none; a tick during a frame is dropped and flags sticky overrun.
module lpf_channel_scheduler #(
    parameter int DIV = 50000,
    parameter int NCH = 4,
    parameter int W   = 20
) (
    input  logic             qzt_clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_ch,
    input  logic [3:0]       cfg_k,
    input  logic             clear_state,
    input  logic [NCH*W-1:0] vin,
    output logic [NCH*W-1:0] vout,
    output logic             vout_valid,
    output logic             sample_tick,
    output logic             busy,
    output logic             overrun
);

    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DCW = $clog2(DIV);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_UPDATE, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         ch_q, ch_d;
    logic [DCW-1:0]        cnt_q;
    logic                  tick_pend_q, tick_pend_d;
    logic                  clr_pend_q, clr_pend_d;
    logic                  overrun_q, overrun_d;
    logic                  accept, clr_now, start, cfg_hit;

    logic [3:0]            k_q  [NCH];
    logic [3:0]            ks_q [NCH];
    logic [W-1:0]          snap_q [NCH];
    logic [W-1:0]          y_q  [NCH];
    logic [W-1:0]          x_q, yv_q, y_new;
    logic [3:0]            kk_q;
    logic signed [W:0]     diff, adj;

    assign sample_tick = enable && (cnt_q == DCW'(DIV - 1));
    assign busy        = (state_q == S_LOAD) || (state_q == S_UPDATE);
    assign vout_valid  = (state_q == S_DONE);
    assign overrun     = overrun_q;
    assign cfg_hit     = cfg_we && (32'(cfg_ch) < NCH);
    assign start       = sample_tick || tick_pend_q;

    // d is one bit wider than the samples so x - y can never wrap
    assign diff  = $signed({x_q[W-1], x_q}) - $signed({yv_q[W-1], yv_q});
    assign adj   = diff >>> kk_q;
    assign y_new = yv_q + adj[W-1:0];

    always_comb begin
        vout = '0;
        for (int c = 0; c < NCH; c++) vout[c*W +: W] = y_q[c];
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        tick_pend_d = tick_pend_q;
        clr_pend_d  = clr_pend_q;
        overrun_d   = overrun_q;
        accept      = 1'b0;
        clr_now     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // a pending clear runs first; a colliding tick is replayed next cycle
                if (clr_pend_q) begin
                    clr_now     = 1'b1;
                    clr_pend_d  = 1'b0;
                    tick_pend_d = start;
                end else if (start) begin
                    accept      = 1'b1;
                    tick_pend_d = 1'b0;
                    ch_d        = '0;
                    state_d     = S_LOAD;
                    if (clear_state) clr_pend_d = 1'b1;
                end else if (clear_state) begin
                    clr_now = 1'b1;
                end
            end
            S_LOAD: state_d = S_UPDATE;
            S_UPDATE: begin
                if (ch_q == CW'(NCH - 1)) begin
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + CW'(1);
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (sample_tick) tick_pend_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE && clear_state) clr_pend_d = 1'b1;
        if (busy && sample_tick) overrun_d = 1'b1;
    end

    always_ff @(posedge qzt_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            cnt_q       <= '0;
            tick_pend_q <= 1'b0;
            clr_pend_q  <= 1'b0;
            overrun_q   <= 1'b0;
            x_q         <= '0;
            yv_q        <= '0;
            kk_q        <= '0;
            for (int c = 0; c < NCH; c++) begin
                k_q[c]    <= '0;
                ks_q[c]   <= '0;
                snap_q[c] <= '0;
                y_q[c]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            tick_pend_q <= tick_pend_d;
            clr_pend_q  <= clr_pend_d;
            overrun_q   <= overrun_d;

            if (!enable || sample_tick) cnt_q <= '0;
            else                        cnt_q <= cnt_q + DCW'(1);

            if (cfg_hit) k_q[cfg_ch[CW-1:0]] <= cfg_k;

            if (accept) begin
                for (int c = 0; c < NCH; c++) begin
                    ks_q[c]   <= (cfg_hit && (int'(cfg_ch) == c)) ? cfg_k : k_q[c];
                    snap_q[c] <= vin[c*W +: W];
                end
            end

            if (state_q == S_LOAD) begin
                x_q  <= snap_q[ch_q];
                yv_q <= y_q[ch_q];
                kk_q <= ks_q[ch_q];
            end

            if (clr_now) begin
                for (int c = 0; c < NCH; c++) y_q[c] <= '0;
            end else if (state_q == S_UPDATE) begin
                y_q[ch_q] <= y_new;
            end
        end
    end

endmodule

// File: tb/tb_lpf_channel_scheduler.sv
module tb_lpf_channel_scheduler;
    localparam int W   = 20;
    localparam int NCH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n, enable, en5, cfg_we, clear_state;
    logic [2:0]       cfg_ch;
    logic [3:0]       cfg_k;
    logic [NCH*W-1:0] vin;
    logic [NCH*W-1:0] vout, vout5;
    logic             vout_valid, sample_tick, busy, overrun;
    logic             vv5, st5, busy5, ov5;

    lpf_channel_scheduler #(.DIV(10), .NCH(NCH), .W(W)) dut (
        .qzt_clk(clk), .reset_n(reset_n), .enable(enable), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_k(cfg_k), .clear_state(clear_state), .vin(vin),
        .vout(vout), .vout_valid(vout_valid), .sample_tick(sample_tick),
        .busy(busy), .overrun(overrun));

    lpf_channel_scheduler #(.DIV(5), .NCH(NCH), .W(W)) dut5 (
        .qzt_clk(clk), .reset_n(reset_n), .enable(en5), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_k(cfg_k), .clear_state(clear_state), .vin(vin),
        .vout(vout5), .vout_valid(vv5), .sample_tick(st5),
        .busy(busy5), .overrun(ov5));

    int     n_assert = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    int     last_tick = 0;
    longint ym [NCH];
    longint xin[NCH];
    int     km [NCH];
    bit     clr_m = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [63:0] ch_of(input logic [NCH*W-1:0] v, input int c);
        logic signed [W-1:0] t;
        t = v[c*W +: W];
        return t;
    endfunction

    // Reference filter step: y + floor((x - y) / 2^k)
    function automatic longint lpf_step(input longint y, input longint x, input int k);
        longint d, p, a;
        d = x - y;
        p = longint'(1) << k;
        if (d >= 0) a = d / p;
        else        a = -((-d + p - 1) / p);
        return y + a;
    endfunction

    task automatic set_vin();
        for (int c = 0; c < NCH; c++) vin[c*W +: W] = W'(xin[c]);
    endtask

    task automatic rand_vin(input int skip);
        for (int c = 0; c < NCH; c++)
            if (c != skip) xin[c] = longint'($urandom_range(0, 1048575)) - 524288;
        set_vin();
    endtask

    task automatic write_k(input int ch, input int k);
        cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_k = 4'(k);
        @(negedge clk);
        cfg_we = 1'b0;
        if (ch < NCH) km[ch] = k;
    endtask

    // Called at the negedge of a DONE cycle (or idle); zeroes filter state from IDLE
    task automatic clear_idle(input string tag);
        enable = 1'b0;
        @(negedge clk);
        clear_state = 1'b1;
        @(negedge clk);
        clear_state = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            chk({tag, " idle clear"}, ch_of(vout, c), 0);
            ym[c] = 0;
        end
    endtask

    task automatic frame(input int exp_lat, input bit zero_chk, input int clr_at,
                         input int wr_at, input int wr_ch, input int wr_k, input string tag);
        int     lat, guard;
        int     ks[NCH];
        longint xs[NCH];
        guard = 0;
        while (sample_tick !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, " tick seen"}, sample_tick, 1);
        last_tick = cyc;
        for (int c = 0; c < NCH; c++) begin
            ks[c] = km[c];
            xs[c] = xin[c];
        end
        if (clr_m) begin
            for (int c = 0; c < NCH; c++) ym[c] = 0;
            clr_m = 1'b0;
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk({tag, " tick one cycle"}, sample_tick, 0);
            if (lat == 1 && zero_chk)
                for (int c = 0; c < NCH; c++) chk({tag, " pending clear"}, ch_of(vout, c), 0);
            if (lat == 2) chk({tag, " busy"}, busy, 1);
            if (lat == clr_at) clear_state = 1'b1;
            if (lat == clr_at + 1) clear_state = 1'b0;
            if (lat == wr_at) begin
                cfg_we = 1'b1; cfg_ch = 3'(wr_ch); cfg_k = 4'(wr_k);
                if (wr_ch < NCH) km[wr_ch] = wr_k;
            end
            if (lat == wr_at + 1) cfg_we = 1'b0;
        end while (vout_valid !== 1'b1 && lat < 40);
        clear_state = 1'b0;
        cfg_we      = 1'b0;
        chk({tag, " valid latency"}, lat, exp_lat);
        chk({tag, " busy low at done"}, busy, 0);
        for (int c = 0; c < NCH; c++) begin
            ym[c] = lpf_step(ym[c], xs[c], ks[c]);
            chk($sformatf("%s vout ch%0d", tag, c), ch_of(vout, c), ym[c]);
        end
        if (clr_at >= 0) clr_m = 1'b1;
    endtask

    initial begin
        int     tprev, guard, nvalid;
        longint t2_exp[4];
        t2_exp = '{250, 437, 577, 682};

        reset_n = 1'b0; enable = 1'b0; en5 = 1'b0; cfg_we = 1'b0;
        cfg_ch = '0; cfg_k = '0; clear_state = 1'b0; vin = '0;
        for (int c = 0; c < NCH; c++) begin ym[c] = 0; km[c] = 0; xin[c] = 0; end
        repeat (2) @(negedge clk);
        chk("reset vout", vout, 0);
        chk("reset busy", busy, 0);
        chk("reset valid", vout_valid, 0);
        chk("reset tick", sample_tick, 0);
        chk("reset overrun", overrun, 0);
        chk("reset overrun5", ov5, 0);
        reset_n = 1'b1;

        // pass-through with k = 0 and extreme values
        xin = '{100, -200, 524287, -524288};
        set_vin();
        enable = 1'b1;
        frame(9, 0, -1, -1, 0, 0, "t1a");
        tprev = last_tick;
        frame(9, 0, -1, -1, 0, 0, "t1b");
        chk("t1 tick period", last_tick - tprev, 10);
        chk("t1 max positive", ch_of(vout, 2), 524287);
        chk("t1 max negative", ch_of(vout, 3), -524288);

        // k0 = 2 step response toward 1000
        clear_idle("t2");
        write_k(0, 2);
        for (int c = 1; c < NCH; c++) write_k(c, int'($urandom_range(0, 15)));
        xin[0] = 1000;
        rand_vin(0);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            frame(9, 0, -1, -1, 0, 0, $sformatf("t2f%0d", i));
            chk($sformatf("t2 y0 step %0d", i), ch_of(vout, 0), t2_exp[i]);
            rand_vin(0);
        end

        // k1 = 15: floor behaviour on tiny differences
        clear_idle("t3a");
        write_k(1, 15);
        xin[1] = -1;
        set_vin();
        enable = 1'b1;
        frame(9, 0, -1, -1, 0, 0, "t3a");
        chk("t3 floor negative", ch_of(vout, 1), -1);
        clear_idle("t3b");
        xin[1] = 1;
        set_vin();
        enable = 1'b1;
        frame(9, 0, -1, -1, 0, 0, "t3b");
        chk("t3 floor positive", ch_of(vout, 1), 0);

        // k writes during a frame apply from the next frame; bad channel ignored
        clear_idle("t5");
        write_k(2, 0);
        xin[2] = 800;
        rand_vin(2);
        enable = 1'b1;
        frame(9, 0, -1, 3, 2, 3, "t5a");
        chk("t5 old k used", ch_of(vout, 2), 800);
        xin[2] = 0;
        rand_vin(2);
        frame(9, 0, -1, 4, 6, 9, "t5b");
        chk("t5 new k used", ch_of(vout, 2), 700);
        rand_vin(2);
        frame(9, 0, -1, -1, 0, 0, "t5c");

        // clear during busy, collides with the next tick; then reset mid-frame
        frame(9, 0, 4, -1, 0, 0, "t6a");
        frame(10, 1, -1, -1, 0, 0, "t6b");
        chk("t6 no overrun from deferred tick", overrun, 0);
        guard = 0;
        while (sample_tick !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
        chk("t6 tick before abort", sample_tick, 1);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("t6 abort vout", vout, 0);
        chk("t6 abort busy", busy, 0);
        chk("t6 abort valid", vout_valid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < NCH; c++) begin ym[c] = 0; km[c] = 0; end
        clr_m = 1'b0;
        nvalid = 0;
        repeat (8) begin
            @(negedge clk);
            if (vout_valid === 1'b1) nvalid++;
        end
        chk("t6 no valid after abort", nvalid, 0);
        rand_vin(-1);
        frame(9, 0, -1, -1, 0, 0, "t6c");

        // DIV = 5: overrun on a re-tick while busy, frames keep completing
        enable = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rand_vin(-1);
        en5 = 1'b1;
        guard = 0;
        while (st5 !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
        chk("t4 first tick", st5, 1);
        chk("t4 overrun before retick", ov5, 0);
        repeat (5) @(negedge clk);
        chk("t4 retick", st5, 1);
        chk("t4 busy at retick", busy5, 1);
        @(negedge clk);
        chk("t4 overrun set", ov5, 1);
        guard = 0;
        while (vv5 !== 1'b1 && guard < 30) begin @(negedge clk); guard++; end
        chk("t4 frame1 valid", vv5, 1);
        for (int c = 0; c < NCH; c++) chk($sformatf("t4 f1 ch%0d", c), ch_of(vout5, c), xin[c]);
        rand_vin(-1);
        @(negedge clk);
        guard = 0;
        while (vv5 !== 1'b1 && guard < 30) begin @(negedge clk); guard++; end
        chk("t4 frame2 valid", vv5, 1);
        for (int c = 0; c < NCH; c++) chk($sformatf("t4 f2 ch%0d", c), ch_of(vout5, c), xin[c]);
        chk("t4 overrun sticky", ov5, 1);
        en5 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
